uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial 8N1 UART transmitter for the board I/O path: accepts a byte from the core over a ready/valid handshake and drives it onto the off-chip TX line. It is the outbound counterpart to the input-conditioning circuits, which bring asynchronous pins into the `clk` domain. This block takes `clk`-domain data out to an asynchronous serial pin. The output is a registered, glitch-free level that idles high.

## Interface
- `CLOCK_FREQ`, default 125_000_000: `clk` frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in bits/s.
- Derived value `SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE` (integer, truncated) gives the cycles per bit. The default is 1085. It must be at least 2.

- `clk`  in  1  system clock. This is the only clock; all logic is on posedge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `data_in`  in  8  byte to send, sampled only at acceptance.
- `data_in_valid`  in  1  producer has a byte.
- `data_in_ready`  out  1  transmitter is idle and can accept a byte.
- `serial_out`  out  1  TX line, registered, idle high.

## Operation
- States:
  - IDLE: `data_in_ready`=1, `serial_out`=1.
  - SEND: `data_in_ready`=0.
- Acceptance happens on a posedge where `data_in_valid && data_in_ready`. At that edge:
  - Load the 10-bit frame {1'b1, `data_in`, 1'b0}.
  - Clear the bit counter (0..9) and the cycle counter (0..SYMBOL_EDGE_TIME-1).
  - Enter SEND.
- Frame format: start bit 0, then data[0]..data[7] (LSB first), then stop bit 1.
- `serial_out` is a flop holding the current frame bit. It must never be a combinational function of inputs.
- Each bit is held for exactly SYMBOL_EDGE_TIME cycles. When the cycle counter reaches SYMBOL_EDGE_TIME-1, it wraps to 0 and the bit index advances.
- After the stop bit's SYMBOL_EDGE_TIME cycles, return to IDLE. `serial_out` stays 1.
- There is no buffering. `data_in_valid` during SEND is ignored, and the producer must hold valid until ready.
- Changes to `data_in` after acceptance have no effect on the frame in flight.
- Cycle-counter width is $clog2(SYMBOL_EDGE_TIME). The bit counter is 4 bits. Neither counter may overflow for any legal parameter set.

## Timing
- Reset values:
  - `serial_out`=1, `data_in_ready`=1, state IDLE, counters 0.
  - Asserting `rst_n` low mid-frame forces `serial_out`=1 immediately (asynchronously). The byte is dropped.
  - After `rst_n` deasserts, the next edge may accept a new byte.
- Frame timing, with acceptance at edge E:
  - `serial_out`=0 from E until E+S, where S = SYMBOL_EDGE_TIME.
  - Data bit i occupies E+(i+1)S to E+(i+2)S.
  - The stop bit starts at E+9S.
- `data_in_ready` timing:
  - Low from E until E+10S.
  - Rises at edge E+10S, after which the block is IDLE.
- Back-to-back transfers:
  - With valid held high, the next acceptance is at edge E+10S+1.
  - So the stop/idle level lasts S+1 cycles and the frame period is 10S+1 cycles.
- Valid and ready high on the same edge always accepts. No combinational path runs from `data_in_valid` to `data_in_ready`.

## Test plan
Run the bench with CLOCK_FREQ=1000 and BAUD_RATE=100, so S=10. Sample the line at mid-bit, i.e. E+5+10k.

1. Reset: hold `rst_n`=0 for 3 cycles, then release. Required: `serial_out`=1 and `data_in_ready`=1 throughout. No activity with valid=0 for 200 cycles.
2. Single byte 0xA5, accepted at E. Required:
   - Mid-bit samples are 0,1,0,1,0,0,1,0,1,1.
   - `data_in_ready`=0 for exactly 100 cycles and is 1 at E+100.
3. Back-to-back 0x00 then 0xFF with valid held. Required:
   - Second acceptance at E+101; its start-bit falling edge comes right after.
   - Stop bit of the first frame lasts 11 cycles.
   - Decoded bytes are 0x00 and 0xFF.
4. Busy-ignore: send 0x3C, then pulse valid with `data_in`=0x77 at E+30. Also change `data_in` to 0xFF at E+40. Required: line decodes 0x3C only, then stays high for 200 cycles.
5. Reset mid-frame: send 0x55 and assert `rst_n`=0 at E+45. Required:
   - `serial_out`=1 before the next edge and `data_in_ready`=1.
   - After release, sending 0x81 decodes cleanly as 0x81.
6. Random: 50 random bytes with random valid gaps, checked by a reference UART receiver model. Required: all bytes match, in order, with no framing errors.

Source files
------------

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: accepts a byte over ready/valid and shifts it out LSB first
// on a registered TX line that idles high. Each bit lasts CLOCK_FREQ/BAUD_RATE cycles.
module uart_transmitter #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CW               = $clog2(SYMBOL_EDGE_TIME);

    localparam logic [CW-1:0] LAST_CYCLE = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [3:0]    LAST_BIT   = 4'd9;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]    state;
    logic [8:0]    frame;    // bits still to send after the one on the line: data then stop
    logic [3:0]    bit_cnt;
    logic [CW-1:0] cyc_cnt;

    // Ready depends only on state, so there is no path from valid back to ready.
    assign data_in_ready = (state == IDLE);

    // The start bit goes straight into serial_out at acceptance, so only the
    // remaining nine frame bits need to be held in the shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            frame      <= '1;
            bit_cnt    <= '0;
            cyc_cnt    <= '0;
            serial_out <= 1'b1;
        end else if (state == IDLE) begin
            if (data_in_valid) begin
                state      <= SEND;
                frame      <= {1'b1, data_in};
                bit_cnt    <= '0;
                cyc_cnt    <= '0;
                serial_out <= 1'b0;
            end
        end else begin
            if (cyc_cnt == LAST_CYCLE) begin
                cyc_cnt <= '0;
                if (bit_cnt == LAST_BIT) begin
                    state      <= IDLE;
                    bit_cnt    <= '0;
                    serial_out <= 1'b1;
                end else begin
                    bit_cnt    <= bit_cnt + 4'd1;
                    serial_out <= frame[0];
                    frame      <= {1'b1, frame[8:1]};
                end
            end else begin
                cyc_cnt <= cyc_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at S=10 cycles per bit, using directed
// frame vectors plus a behavioural UART receiver model for random traffic.
module tb_uart_transmitter;

    localparam int S    = 10;
    localparam int HALF = S / 2;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic       serial_out;

    uart_transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    // Receiver model: finds a falling edge on an idle line, samples mid-bit.
    typedef struct {
        logic [7:0] data;
        logic       frame_ok;
    } rx_t;

    rx_t rx_q[$];

    initial begin
        logic       prev;
        logic       start_bit;
        logic       stop_bit;
        logic [7:0] d;
        prev = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (prev && !serial_out) begin
                repeat (HALF) @(posedge clk);
                #1 start_bit = serial_out;
                for (int i = 0; i < 8; i++) begin
                    repeat (S) @(posedge clk);
                    #1 d[i] = serial_out;
                end
                repeat (S) @(posedge clk);
                #1 stop_bit = serial_out;
                rx_q.push_back('{data: d, frame_ok: (!start_bit && stop_bit)});
                prev = 1'b1;
            end else begin
                prev = serial_out;
            end
        end
    end

    // Called at 1 time unit after a posedge; returns 1 time unit after the acceptance edge.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        while (!data_in_ready && waited < 2000) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!data_in_ready) check("ready_timeout", 0, 1);
        data_in       = b;
        data_in_valid = 1'b1;
        @(posedge clk); #1;
        data_in_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int waited;
        waited = 0;
        while (rx_q.size() < n && waited < 3000) begin
            @(posedge clk); #1;
            waited++;
        end
        if (rx_q.size() < n) check("rx_timeout", rx_q.size(), n);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // bit k is the required mid-bit sample k: start, d0..d7, stop
        int         busy;   // cycles data_in_ready stays low
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [9:0] samples;
        int         low_cnt;
        int         high_cnt;
        int         fall_n;
        int         idle_low;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        rx_t        r;

        vecs[0] = '{data: 8'hA5, line: 10'b1_1010_0101_0, busy: 100};
        vecs[1] = '{data: 8'h00, line: 10'b1_0000_0000_0, busy: 100};
        vecs[2] = '{data: 8'hFF, line: 10'b1_1111_1111_0, busy: 100};
        vecs[3] = '{data: 8'h3C, line: 10'b1_0011_1100_0, busy: 100};
        vecs[4] = '{data: 8'h81, line: 10'b1_1000_0001_0, busy: 100};

        rst_n         = 1'b0;
        data_in       = 8'h00;
        data_in_valid = 1'b0;

        // 1. reset and idle
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_serial_out", int'(serial_out), 1);
            check("reset_ready", int'(data_in_ready), 1);
        end
        rst_n = 1'b1;
        idle_low = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (!serial_out || !data_in_ready) idle_low++;
        end
        check("idle_no_activity", idle_low, 0);
        check("idle_no_rx", rx_q.size(), 0);

        // 2. directed frames, mid-bit samples and busy duration
        foreach (vecs[v]) begin
            send_byte(vecs[v].data);
            low_cnt = data_in_ready ? 0 : 1;
            samples = '0;
            for (int n = 1; n <= 100; n++) begin
                @(posedge clk); #1;
                if (n % S == HALF) samples[n / S] = serial_out;
                if (n < 100 && !data_in_ready) low_cnt++;
                if (n == 100) check("ready_back_at_E+100", int'(data_in_ready), 1);
            end
            check($sformatf("line_%02h", vecs[v].data), int'(samples), int'(vecs[v].line));
            check($sformatf("busy_%02h", vecs[v].data), low_cnt, vecs[v].busy);
        end
        repeat (20) @(posedge clk); #1;
        rx_q.delete();

        // 3. back-to-back 0x00 then 0xFF with valid held
        data_in       = 8'h00;
        data_in_valid = 1'b1;
        @(posedge clk); #1;
        data_in  = 8'hFF;
        high_cnt = 0;
        fall_n   = 0;
        for (int n = 1; n <= 130 && fall_n == 0; n++) begin
            @(posedge clk); #1;
            if (n >= 90) begin
                if (serial_out) high_cnt++;
                else begin
                    fall_n        = n;
                    data_in_valid = 1'b0;
                end
            end
        end
        data_in_valid = 1'b0;
        check("b2b_second_accept", fall_n, 101);
        check("b2b_stop_len", high_cnt, 11);
        wait_rx(2);
        if (rx_q.size() >= 2) begin
            r = rx_q.pop_front();
            check("b2b_byte0", int'(r.data), 8'h00);
            check("b2b_frame0", int'(r.frame_ok), 1);
            r = rx_q.pop_front();
            check("b2b_byte1", int'(r.data), 8'hFF);
            check("b2b_frame1", int'(r.frame_ok), 1);
        end
        repeat (20) @(posedge clk); #1;
        rx_q.delete();

        // 4. valid pulse and data change while busy are ignored
        send_byte(8'h3C);
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (n == 29) begin
                data_in       = 8'h77;
                data_in_valid = 1'b1;
            end
            if (n == 30) data_in_valid = 1'b0;
            if (n == 40) data_in = 8'hFF;
        end
        idle_low = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (!serial_out) idle_low++;
        end
        check("busy_ignore_idle", idle_low, 0);
        check("busy_ignore_count", rx_q.size(), 1);
        if (rx_q.size() >= 1) begin
            r = rx_q.pop_front();
            check("busy_ignore_byte", int'(r.data), 8'h3C);
        end
        rx_q.delete();

        // 5. reset mid-frame, then a clean frame
        send_byte(8'h55);
        repeat (44) @(posedge clk);
        #1 check("pre_reset_line", int'(serial_out), 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_serial_out", int'(serial_out), 1);
        check("mid_reset_ready", int'(data_in_ready), 1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (120) @(posedge clk);
        #1 rx_q.delete();
        send_byte(8'h81);
        wait_rx(1);
        if (rx_q.size() >= 1) begin
            r = rx_q.pop_front();
            check("after_reset_byte", int'(r.data), 8'h81);
            check("after_reset_frame", int'(r.frame_ok), 1);
        end
        repeat (20) @(posedge clk); #1;
        rx_q.delete();

        // 6. random bytes with random gaps
        for (int i = 0; i < 50; i++) begin
            repeat ($urandom_range(0, 15)) @(posedge clk);
            #1;
            b = 8'($urandom);
            exp_q.push_back(b);
            send_byte(b);
        end
        wait_rx(50);
        check("rand_count", rx_q.size(), 50);
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            r = rx_q.pop_front();
            b = exp_q.pop_front();
            check("rand_byte", int'(r.data), int'(b));
            check("rand_frame", int'(r.frame_ok), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
